fc_topk_collector: RTL and testbench

Consumes the classifier logit stream (valid, class index, signed 8-bit logit) from the FC layer of the MobileNet accelerator top, one logit per valid cycle. Keeps a running sorted top-K list using single-cycle parallel insertion. After the last class it streams the K winners out over a valid/ready port and holds the top-1 result for status readout.

---
 rtl/fc_topk_collector.sv | 186 ++++++++++++++++++
 tb/tb_fc_topk_collector.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_topk_collector.sv
// Top-K logit collector for the classifier output stream.
// Keeps a sorted list of the K largest logits of a frame using a
// single-cycle parallel insert, then streams the winners out by rank.
//
// Output handshake: an entry transfers on every rising CLK edge where
// out_valid and out_ready are both high; out_* stays stable while
// out_valid is high and out_ready is low. The input side has no
// backpressure: in_valid is either accepted or dropped in its cycle.
module fc_topk_collector #(
  parameter int K           = 5,
  parameter int NUM_CLASSES = 1001,
  parameter int IDX_W       = 11,
  parameter int RANK_W      = 3
) (
  input  logic                     CLK,
  input  logic                     RESETn,
  input  logic                     start,
  input  logic                     in_valid,
  input  logic [IDX_W-1:0]         in_class_idx,
  input  logic signed [7:0]        in_logit,
  output logic                     busy,
  output logic                     done,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [RANK_W-1:0]        out_rank,
  output logic [IDX_W-1:0]         out_class_idx,
  output logic signed [7:0]        out_logit,
  output logic [IDX_W-1:0]         top1_class_idx,
  output logic signed [7:0]        top1_logit,
  output logic [IDX_W-1:0]         logit_count,
  output logic                     err_overflow,
  output logic                     in_ignored,
  output logic [1:0]               dbg_state
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_EMIT    = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  localparam logic [IDX_W:0]    NC_W      = (IDX_W+1)'(NUM_CLASSES);
  localparam logic [RANK_W-1:0] LAST_RANK = RANK_W'(K-1);

  logic [1:0]              state;
  logic [RANK_W-1:0]       rank;

  // Sorted list: entry 0 is the largest; occupied entries are contiguous from 0.
  logic                    e_occ   [K];
  logic [IDX_W-1:0]        e_idx   [K];
  logic signed [7:0]       e_logit [K];

  // List as it would look after inserting the current input.
  logic                    n_occ   [K];
  logic [IDX_W-1:0]        n_idx   [K];
  logic signed [7:0]       n_logit [K];

  logic [3:0]              ins_pos;
  logic                    accept;
  logic                    drop;
  logic                    last_accept;
  logic                    xfer;

  assign accept      = in_valid && !start && (state == S_COLLECT) &&
                       ({1'b0, in_class_idx} < NC_W);
  assign drop        = in_valid && !accept;
  assign last_accept = accept && (({1'b0, logit_count} + (IDX_W+1)'(1)) == NC_W);
  assign xfer        = (state == S_EMIT) && out_ready;

  // Insert position: count of occupied entries that are >= the new logit,
  // so an equal earlier arrival stays ahead of the newcomer.
  always_comb begin
    ins_pos = '0;
    for (int i = 0; i < K; i++) begin
      if (e_occ[i] && (e_logit[i] >= in_logit)) ins_pos = ins_pos + 4'd1;
    end
  end

  // Build the shifted list; entry K-1 falls off the end, p == K leaves it intact.
  always_comb begin
    if (ins_pos == 4'd0) begin
      n_occ[0]   = 1'b1;
      n_idx[0]   = in_class_idx;
      n_logit[0] = in_logit;
    end else begin
      n_occ[0]   = e_occ[0];
      n_idx[0]   = e_idx[0];
      n_logit[0] = e_logit[0];
    end
    for (int i = 1; i < K; i++) begin
      if (4'(i) < ins_pos) begin
        n_occ[i]   = e_occ[i];
        n_idx[i]   = e_idx[i];
        n_logit[i] = e_logit[i];
      end else if (4'(i) == ins_pos) begin
        n_occ[i]   = 1'b1;
        n_idx[i]   = in_class_idx;
        n_logit[i] = in_logit;
      end else begin
        n_occ[i]   = e_occ[i-1];
        n_idx[i]   = e_idx[i-1];
        n_logit[i] = e_logit[i-1];
      end
    end
  end

  // Control FSM, emit rank, frame counter and status flags.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state        <= S_IDLE;
      rank         <= '0;
      logit_count  <= '0;
      err_overflow <= 1'b0;
      in_ignored   <= 1'b0;
    end else begin
      in_ignored <= drop;
      if (start) begin
        state        <= S_COLLECT;
        rank         <= '0;
        logit_count  <= '0;
        err_overflow <= 1'b0;
      end else begin
        if (drop && (state != S_IDLE)) err_overflow <= 1'b1;
        if (accept && ({1'b0, logit_count} < NC_W)) logit_count <= logit_count + 1'b1;
        case (state)
          S_COLLECT: if (last_accept) state <= S_EMIT;
          S_EMIT: begin
            if (xfer) begin
              if (rank == LAST_RANK) state <= S_DONE;
              else rank <= rank + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Sorted list storage and registered top-1 copy, updated on the same edge.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      for (int i = 0; i < K; i++) begin
        e_occ[i]   <= 1'b0;
        e_idx[i]   <= '0;
        e_logit[i] <= '0;
      end
      top1_class_idx <= '0;
      top1_logit     <= '0;
    end else if (start) begin
      for (int i = 0; i < K; i++) begin
        e_occ[i]   <= 1'b0;
        e_idx[i]   <= '0;
        e_logit[i] <= '0;
      end
      top1_class_idx <= '0;
      top1_logit     <= '0;
    end else if (accept) begin
      for (int i = 0; i < K; i++) begin
        e_occ[i]   <= n_occ[i];
        e_idx[i]   <= n_idx[i];
        e_logit[i] <= n_logit[i];
      end
      top1_class_idx <= n_idx[0];
      top1_logit     <= n_logit[0];
    end
  end

  // Status and ranked output; empty slots read back as idx 0 / -128.
  always_comb begin
    busy          = (state == S_COLLECT) || (state == S_EMIT);
    done          = (state == S_DONE);
    out_valid     = (state == S_EMIT);
    out_rank      = rank;
    out_class_idx = '0;
    out_logit     = '0;
    if (state == S_EMIT) begin
      if (e_occ[rank]) begin
        out_class_idx = e_idx[rank];
        out_logit     = e_logit[rank];
      end else begin
        out_logit     = -8'sd128;
      end
    end
    dbg_state = state;
  end

endmodule

// File: tb/tb_fc_topk_collector.sv
// Bench for fc_topk_collector: random and directed frames, reference top-K by
// selection over the recorded arrivals, scoreboard queue drained by a monitor.
module tb_fc_topk_collector;
  localparam int K      = 5;
  localparam int NC     = 1001;
  localparam int IDX_W  = 11;
  localparam int RANK_W = 3;
  localparam int PW     = RANK_W + IDX_W + 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // main instance (default parameters)
  logic                start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [IDX_W-1:0]    in_class_idx = '0;
  logic signed [7:0]   in_logit = '0;
  logic                busy, done, out_valid, err_overflow, in_ignored;
  logic [RANK_W-1:0]   out_rank;
  logic [IDX_W-1:0]    out_class_idx, top1_class_idx, logit_count;
  logic signed [7:0]   out_logit, top1_logit;
  logic [1:0]          dbg_state;

  // small instance: fewer classes than K
  logic                s_start = 1'b0, s_in_valid = 1'b0, s_out_ready = 1'b1;
  logic [IDX_W-1:0]    s_in_class_idx = '0;
  logic signed [7:0]   s_in_logit = '0;
  logic                s_busy, s_done, s_out_valid, s_err_overflow, s_in_ignored;
  logic [RANK_W-1:0]   s_out_rank;
  logic [IDX_W-1:0]    s_out_class_idx, s_top1_class_idx, s_logit_count;
  logic signed [7:0]   s_out_logit, s_top1_logit;
  logic [1:0]          s_dbg_state;

  fc_topk_collector #(.K(K), .NUM_CLASSES(NC), .IDX_W(IDX_W), .RANK_W(RANK_W)) dut (
    .CLK(clk), .RESETn(rst_n), .start(start), .in_valid(in_valid),
    .in_class_idx(in_class_idx), .in_logit(in_logit), .busy(busy), .done(done),
    .out_valid(out_valid), .out_ready(out_ready), .out_rank(out_rank),
    .out_class_idx(out_class_idx), .out_logit(out_logit),
    .top1_class_idx(top1_class_idx), .top1_logit(top1_logit),
    .logit_count(logit_count), .err_overflow(err_overflow),
    .in_ignored(in_ignored), .dbg_state(dbg_state)
  );

  fc_topk_collector #(.K(K), .NUM_CLASSES(3), .IDX_W(IDX_W), .RANK_W(RANK_W)) dut_small (
    .CLK(clk), .RESETn(rst_n), .start(s_start), .in_valid(s_in_valid),
    .in_class_idx(s_in_class_idx), .in_logit(s_in_logit), .busy(s_busy), .done(s_done),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_rank(s_out_rank),
    .out_class_idx(s_out_class_idx), .out_logit(s_out_logit),
    .top1_class_idx(s_top1_class_idx), .top1_logit(s_top1_logit),
    .logit_count(s_logit_count), .err_overflow(s_err_overflow),
    .in_ignored(s_in_ignored), .dbg_state(s_dbg_state)
  );

  // scoreboard state
  int checks = 0;
  int failures = 0;
  logic [PW-1:0] exp_q[$];
  int arr_idx[$];
  int arr_logit[$];
  logic [PW-1:0] exp_top[K];
  int ready_mode = 0;
  logic [3:0] ready_pat = 4'b1001;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: pick the K largest by repeated selection; strict '>' keeps the
  // earliest arrival ahead on ties; missing ranks become idx 0 / -128.
  task automatic compute_model();
    bit used[$];
    int best;
    used.delete();
    foreach (arr_idx[j]) used.push_back(1'b0);
    for (int r = 0; r < K; r++) begin
      best = -1;
      foreach (arr_idx[j]) begin
        if (!used[j] && (best < 0 || arr_logit[j] > arr_logit[best])) best = j;
      end
      if (best >= 0) begin
        used[best] = 1'b1;
        exp_top[r] = {RANK_W'(r), IDX_W'(arr_idx[best]), 8'(arr_logit[best])};
      end else begin
        exp_top[r] = {RANK_W'(r), IDX_W'(0), 8'h80};
      end
    end
  endtask

  // driver: one input beat, optional idle gap afterwards
  task automatic drive_logit(input int idx, input int lg, input bit expect_accept);
    in_valid = 1'b1;
    in_class_idx = IDX_W'(idx);
    in_logit = 8'(lg);
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (expect_accept) begin
      arr_idx.push_back(idx);
      arr_logit.push_back(lg);
    end
  endtask

  task automatic idle_gap();
    if ($urandom_range(3) == 0) begin
      @(posedge clk); #1;
    end
  endtask

  // mode 0: idx%100-50, 1: random, 2: fixed 8 then -128, 3: heavy ties, random idx
  task automatic run_frame(input int mode, input int n, input bit valid_at_start, input bit inject_bad);
    int idx, lg;
    int pat8[8] = '{3, -7, 127, 3, -128, 0, 127, 5};
    int tie_set[4] = '{-128, -1, 0, 127};
    arr_idx.delete();
    arr_logit.delete();
    start = 1'b1;
    in_valid = valid_at_start;
    in_class_idx = IDX_W'(3);
    in_logit = 8'sd9;
    @(posedge clk); #1;
    start = 1'b0;
    in_valid = 1'b0;
    if (valid_at_start) begin
      check("ignored_on_start", in_ignored, 1);
      check("err_clear_on_start", err_overflow, 0);
    end
    check("count_cleared", logit_count, 0);
    check("busy_collect", busy, 1);
    for (int i = 0; i < n; i++) begin
      if (inject_bad && i == n / 2) begin
        drive_logit(NC, 5, 1'b0);
        check("bad_idx_ignored", in_ignored, 1);
        check("bad_idx_err", err_overflow, 1);
      end
      case (mode)
        0: begin idx = i; lg = (i % 100) - 50; end
        1: begin idx = i; lg = int'($urandom_range(255)) - 128; end
        2: begin idx = i; lg = (i < 8) ? pat8[i] : -128; end
        default: begin idx = int'($urandom_range(NC - 1)); lg = tie_set[$urandom_range(3)]; end
      endcase
      drive_logit(idx, lg, 1'b1);
      idle_gap();
    end
    if (n == NC) begin
      check("count_full", logit_count, NC);
      compute_model();
      for (int r = 0; r < K; r++) exp_q.push_back(exp_top[r]);
    end
  endtask

  task automatic wait_done();
    for (int c = 0; c < 200 && !done; c++) @(negedge clk);
    check("done_reached", done, 1);
    check("busy_after_done", busy, 0);
    check("valid_after_done", out_valid, 0);
    check("queue_drained", exp_q.size(), 0);
    check("top1_idx", top1_class_idx, {{(32-IDX_W){1'b0}}, exp_top[0][IDX_W+7:8]});
    check("top1_logit", {24'd0, top1_logit}, {24'd0, exp_top[0][7:0]});
  endtask

  // out_ready driver
  initial begin
    int pi = 0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0: out_ready = 1'($urandom_range(1));
        1: begin out_ready = ready_pat[3 - pi]; pi = (pi + 1) % 4; end
        default: out_ready = 1'b1;
      endcase
    end
  end

  // monitor: pops on every transfer, checks stability while stalled
  logic [PW-1:0] prev_out;
  bit held = 1'b0;
  always @(negedge clk) begin
    logic [PW-1:0] cur, e;
    if (rst_n && out_valid) begin
      cur = {out_rank, out_class_idx, out_logit};
      if (held) check("hold_stable", cur, prev_out);
      if (out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_emit actual=%0h required=none", cur);
        end else begin
          e = exp_q.pop_front();
          check("emit_entry", cur, e);
        end
        held = 1'b0;
      end else begin
        held = 1'b1;
        prev_out = cur;
      end
    end else begin
      held = 1'b0;
    end
  end

  initial begin
    int got;
    // reset values
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_rank", out_rank, 0);
    check("rst_out_idx", out_class_idx, 0);
    check("rst_out_logit", {24'd0, out_logit}, 0);
    check("rst_top1_idx", top1_class_idx, 0);
    check("rst_top1_logit", {24'd0, top1_logit}, 0);
    check("rst_count", logit_count, 0);
    check("rst_err", err_overflow, 0);
    check("rst_ignored", in_ignored, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // drop in IDLE before any start: pulse only, no error
    drive_logit(3, 7, 1'b0);
    check("idle_ignored", in_ignored, 1);
    check("idle_no_err", err_overflow, 0);
    @(posedge clk); #1;
    check("idle_ignored_pulse", in_ignored, 0);

    // frame A: idx%100-50 pattern
    ready_mode = 0;
    run_frame(0, NC, 1'b0, 1'b0);
    wait_done();
    check("patA_top1_idx", top1_class_idx, 99);
    check("patA_top1_logit", {24'd0, top1_logit}, 32'd49);

    // drop in DONE sets the error, done holds
    @(posedge clk); #1;
    drive_logit(5, 1, 1'b0);
    check("done_ignored", in_ignored, 1);
    check("done_err", err_overflow, 1);
    check("done_holds", done, 1);
    @(posedge clk); #1;
    check("done_ignored_pulse", in_ignored, 0);

    // restart mid-COLLECT, then a fresh full random frame
    run_frame(1, 500, 1'b1, 1'b0);
    run_frame(1, NC, 1'b1, 1'b0);
    wait_done();
    check("restart_err_clear", err_overflow, 0);

    // heavy ties, out-of-range index, stalled output 1,0,0,1
    ready_mode = 1;
    run_frame(3, NC, 1'b0, 1'b1);
    wait_done();
    check("bad_idx_err_sticky", err_overflow, 1);

    // fixed eight-value pattern followed by -128s
    ready_mode = 0;
    run_frame(2, NC, 1'b0, 1'b0);
    wait_done();
    check("pat8_top1_idx", top1_class_idx, 2);
    check("pat8_top1_logit", {24'd0, top1_logit}, 32'd127);

    // reset during EMIT drops outputs immediately
    run_frame(1, NC, 1'b0, 1'b0);
    for (int c = 0; c < 20 && !out_valid; c++) @(negedge clk);
    check("emit_seen", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_emit_valid", out_valid, 0);
    check("rst_emit_done", done, 0);
    check("rst_emit_busy", busy, 0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // fewer classes than K: padded ranks
    arr_idx.delete();
    arr_logit.delete();
    s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_in_valid = 1'b1;
      s_in_class_idx = IDX_W'($urandom_range(2));
      s_in_logit = 8'($urandom_range(255));
      arr_idx.push_back(int'(s_in_class_idx));
      arr_logit.push_back(int'(s_in_logit));
      @(posedge clk); #1;
      s_in_valid = 1'b0;
    end
    compute_model();
    got = 0;
    for (int c = 0; c < 30 && got < K; c++) begin
      @(negedge clk);
      if (s_out_valid) begin
        check("small_emit", {s_out_rank, s_out_class_idx, s_out_logit}, exp_top[got]);
        got++;
      end
    end
    check("small_transfers", got, K);
    @(negedge clk);
    check("small_done", s_done, 1);
    check("small_valid_low", s_out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
